mdiv_opnd_rdout: RTL

Operand read-out unit for the modular-inverse/division datapath. It captures a 256-bit result in parallel and delivers it over a valid/ready stream, either as eight 32-bit words (least-significant word first) or as 256 single bits (LSB first). Both orders match what the divider's operand load register expects: word load shifts toward the low word, and bit load enters at bit 255 and shifts right. An operand can therefore be moved between the divider and the core, or between divider instances, without reordering.

---
 rtl/mdiv_opnd_rdout.sv | 103 ++++++++++
 1 files changed

// File: rtl/mdiv_opnd_rdout.sv
// Operand read-out: captures a 256-bit result and streams it as 8 words or 256 bits, LSB first.
// Latency: first item valid the cycle after capture; one item per cycle while o_rdy is high.
// Backpressure: o_rdy low holds sreg, cnt and all outputs; cap_rdy low while busy.
module mdiv_opnd_rdout #(
    parameter int DW = 32,
    parameter int NW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_vld,
    output logic             cap_rdy,
    input  logic             cap_mode,
    input  logic [DW*NW-1:0] cap_data,
    input  logic             abort,
    output logic             o_vld,
    input  logic             o_rdy,
    output logic [DW-1:0]    o_word,
    output logic             o_bit,
    output logic             o_last,
    output logic             rem_zero,
    output logic             busy,
    output logic             done
);
    localparam int TW = DW * NW;
    localparam int CW = $clog2(TW);
    localparam logic [CW-1:0] LAST_W = CW'(NW - 1);
    localparam logic [CW-1:0] LAST_B = CW'(TW - 1);

    typedef enum logic [1:0] {IDLE, WORD, BIT} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] sreg, sreg_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          done_nxt;
    logic          hs;

    assign busy     = (state != IDLE);
    assign cap_rdy  = (state == IDLE);
    assign o_vld    = busy;
    assign o_word   = sreg[DW-1:0];
    assign o_bit    = sreg[0];
    assign o_last   = ((state == WORD) && (cnt == LAST_W)) ||
                      ((state == BIT)  && (cnt == LAST_B));
    assign rem_zero = busy && (sreg == '0);
    assign hs       = o_vld && o_rdy;

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cap_vld) begin
                    sreg_nxt  = cap_data;
                    cnt_nxt   = '0;
                    state_nxt = cap_mode ? BIT : WORD;
                end
            end
            WORD, BIT: begin
                if (hs) begin
                    if (o_last) begin
                        // Final item leaves nothing behind so the next capture starts clean.
                        state_nxt = IDLE;
                        sreg_nxt  = '0;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        sreg_nxt = (state == WORD) ? {{DW{1'b0}}, sreg[TW-1:DW]}
                                                   : {1'b0, sreg[TW-1:1]};
                        cnt_nxt  = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sreg_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
        // Flush wins over everything, including a capture in the same cycle.
        if (abort) begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end
endmodule
